// File: rtl/multicycle_controller.sv
// multicycle_controller
//
// Control unit for a multicycle RV32I datapath. A Moore FSM steps each instruction through
// FETCH/DECODE/EXECUTE/MEM/WB, sharing one ALU and one unified memory. It adds a memory-ready
// handshake with wait states, a sticky illegal-opcode trap and a retired-instruction counter.
//
// Configuration macro:
//   RV_PERF_CNT_EN  defined   -> instret counts retired instructions (wraps modulo 2^CNT_W)
//                   undefined -> counter logic removed, instret tied to 0 (port kept)
//
// Parameters:
//   CNT_W      width of the retired-instruction counter
//   HANDSHAKE  1: memory states wait for mem_ready; 0: memory is single-cycle, mem_ready ignored
//
// Ports:
//   clk, reset   rising-edge clock, asynchronous active-high reset
//   op           opcode from the instruction register
//   zero         ALU zero flag (branch resolution)
//   mem_ready    memory access completes this cycle
//   pc_write     PC enable = pc_update | (branch & zero)
//   adr_src      memory address select (0 PC, 1 ALU result register)
//   mem_read     memory read request
//   mem_write    memory write strobe
//   ir_write     instruction register / old-PC enable
//   reg_write    register file write enable
//   result_src   result mux (00 ALUOut, 01 Data, 10 ALUResult)
//   alu_src_a    ALU A mux (00 PC, 01 OldPC, 10 rs1)
//   alu_src_b    ALU B mux (00 rs2, 01 imm, 10 constant 4)
//   alu_op       ALU operation (00 add, 01 sub, 10 R-type funct, 11 I-type funct)
//   imm_src      immediate type from op (00 I, 01 S, 10 B, 11 J; 00 when unknown)
//   illegal_op   sticky trap flag, cleared only by reset
//   instret      retired-instruction count
//   state_dbg    current state encoding

module multicycle_controller #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned HANDSHAKE = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       op,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             adr_src,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic [1:0]       result_src,
  output logic [1:0]       alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic [1:0]       imm_src,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instret,
  output logic [3:0]       state_dbg
);

  localparam logic [6:0] OpLw   = 7'b0000011;
  localparam logic [6:0] OpSw   = 7'b0100011;
  localparam logic [6:0] OpRtyp = 7'b0110011;
  localparam logic [6:0] OpItyp = 7'b0010011;
  localparam logic [6:0] OpJal  = 7'b1101111;
  localparam logic [6:0] OpBeq  = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecR    = 4'd6,
    StExecI    = 4'd7,
    StJal      = 4'd8,
    StAluWb    = 4'd9,
    StBeq      = 4'd10,
    StTrap     = 4'd11
  } state_e;

  state_e state_q, state_d;
  logic   illegal_op_q, illegal_op_d;

  // Memory completion as seen by the FSM; without the handshake every access is one cycle.
  logic mem_rdy;
  assign mem_rdy = (HANDSHAKE != 0) ? mem_ready : 1'b1;

  // Raw (ungated) enables produced by the state decode.
  logic pc_update;
  logic branch;
  logic mem_read_c;
  logic mem_write_c;
  logic ir_write_c;
  logic reg_write_c;

  // ---------------------------------------------------------------------------------------------
  // State register and sticky trap flag
  // ---------------------------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StFetch;
      illegal_op_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      illegal_op_q <= illegal_op_d;
    end
  end

  // Flag rises on the same edge that enters TRAP and never falls until reset.
  always_comb begin
    illegal_op_d = illegal_op_q | (state_d == StTrap);
  end

  // ---------------------------------------------------------------------------------------------
  // Next-state and Moore outputs
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    pc_update   = 1'b0;
    branch      = 1'b0;
    mem_read_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    adr_src     = 1'b0;
    result_src  = 2'b00;
    alu_src_a   = 2'b00;
    alu_src_b   = 2'b00;
    alu_op      = 2'b00;

    unique case (state_q)
      StFetch: begin
        // PC + 4 computed on the ALU while the instruction is read.
        mem_read_c = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        if (mem_rdy) begin
          ir_write_c = 1'b1;
          pc_update  = 1'b1;
          state_d    = StDecode;
        end
      end
      StDecode: begin
        // OldPC + imm: branch/jump target precomputed into ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (op)
          OpLw, OpSw: state_d = StMemAdr;
          OpRtyp:     state_d = StExecR;
          OpItyp:     state_d = StExecI;
          OpJal:      state_d = StJal;
          OpBeq:      state_d = StBeq;
          default:    state_d = StTrap;
        endcase
      end
      StMemAdr: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (op == OpSw) ? StMemWrite : StMemRead;
      end
      StMemRead: begin
        adr_src    = 1'b1;
        mem_read_c = 1'b1;
        if (mem_rdy) begin
          state_d = StMemWb;
        end
      end
      StMemWb: begin
        result_src  = 2'b01;
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      StMemWrite: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
        if (mem_rdy) begin
          state_d = StFetch;
        end
      end
      StExecR: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = StAluWb;
      end
      StExecI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b11;
        state_d   = StAluWb;
      end
      StJal: begin
        // Link value OldPC + 4 on the ALU; target already sits in ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_update = 1'b1;
        state_d   = StAluWb;
      end
      StAluWb: begin
        reg_write_c = 1'b1;
        state_d     = StFetch;
      end
      StBeq: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b01;
        branch    = 1'b1;
        state_d   = StFetch;
      end
      StTrap: begin
        state_d = StTrap;
      end
      default: begin
        state_d = StFetch;
      end
    endcase
  end

  // Enables and strobes are forced low for as long as reset is held.
  always_comb begin
    pc_write  = ~reset & (pc_update | (branch & zero));
    mem_read  = ~reset & mem_read_c;
    mem_write = ~reset & mem_write_c;
    ir_write  = ~reset & ir_write_c;
    reg_write = ~reset & reg_write_c;
  end

  // ---------------------------------------------------------------------------------------------
  // Immediate type, decoded straight from the opcode
  // ---------------------------------------------------------------------------------------------
  always_comb begin
    case (op)
      OpSw:    imm_src = 2'b01;
      OpBeq:   imm_src = 2'b10;
      OpJal:   imm_src = 2'b11;
      default: imm_src = 2'b00;
    endcase
  end

  assign illegal_op = illegal_op_q;
  assign state_dbg  = state_q;

  // ---------------------------------------------------------------------------------------------
  // Retired-instruction counter
  // ---------------------------------------------------------------------------------------------
`ifdef RV_PERF_CNT_EN
  logic [CNT_W-1:0] instret_q, instret_d;
  logic             retire;

  // An instruction retires on its final cycle, i.e. the one that returns to FETCH.
  always_comb begin
    retire = (state_q == StMemWb) || (state_q == StAluWb) || (state_q == StBeq) ||
             ((state_q == StMemWrite) && mem_rdy);
    instret_d = retire ? (instret_q + CNT_W'(1)) : instret_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instret_q <= '0;
    end else begin
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`else
  assign instret = '0;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller. The stimulus expands each instruction into its
// expected per-cycle control words (from the instruction class and chosen wait counts) and queues
// them; a monitor on the falling edge pops one word per queued cycle and compares it.
module tb_multicycle_controller;

  localparam int unsigned CW = 4;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_BEQ = 7'b1100011;

  localparam int PH_FETCH  = 0;
  localparam int PH_DECODE = 1;
  localparam int PH_MEMADR = 2;
  localparam int PH_MEMRD  = 3;
  localparam int PH_MEMWB  = 4;
  localparam int PH_MEMWR  = 5;
  localparam int PH_EXECR  = 6;
  localparam int PH_EXECI  = 7;
  localparam int PH_JAL    = 8;
  localparam int PH_ALUWB  = 9;
  localparam int PH_BEQ    = 10;
  localparam int PH_TRAP   = 11;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [6:0]    op = 7'd0;
  logic          zero = 1'b0;
  logic          mem_ready = 1'b0;
  logic          pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, illegal_op;
  logic [1:0]    result_src, alu_src_a, alu_src_b, alu_op, imm_src;
  logic [CW-1:0] instret;
  logic [3:0]    state_dbg;

  multicycle_controller #(
    .CNT_W     (CW),
    .HANDSHAKE (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_write   (pc_write),
    .adr_src    (adr_src),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .reg_write  (reg_write),
    .result_src (result_src),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .alu_op     (alu_op),
    .imm_src    (imm_src),
    .illegal_op (illegal_op),
    .instret    (instret),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic          pc_write;
    logic          adr_src;
    logic          mem_read;
    logic          mem_write;
    logic          ir_write;
    logic          reg_write;
    logic [1:0]    result_src;
    logic [1:0]    alu_src_a;
    logic [1:0]    alu_src_b;
    logic [1:0]    alu_op;
    logic [1:0]    imm_src;
    logic          illegal_op;
    logic [CW-1:0] instret;
  } cw_t;

  typedef struct {
    cw_t   w;
    string tag;
  } exp_t;

  exp_t          exp_q[$];
  int            n_checks = 0;
  int            n_pass = 0;
  logic [CW-1:0] retired = '0;
  logic [6:0]    cur_op = 7'd0;

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [1:0] imm_of(input logic [6:0] o);
    if (o == OP_SW) return 2'b01;
    if (o == OP_BEQ) return 2'b10;
    if (o == OP_JAL) return 2'b11;
    return 2'b00;
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
`ifdef RV_PERF_CNT_EN
    return retired;
`else
    return '0;
`endif
  endfunction

  function automatic string ph_name(input int ph);
    case (ph)
      PH_FETCH:  return "fetch";
      PH_DECODE: return "decode";
      PH_MEMADR: return "memadr";
      PH_MEMRD:  return "memread";
      PH_MEMWB:  return "memwb";
      PH_MEMWR:  return "memwrite";
      PH_EXECR:  return "execr";
      PH_EXECI:  return "execi";
      PH_JAL:    return "jal";
      PH_ALUWB:  return "aluwb";
      PH_BEQ:    return "beq";
      default:   return "trap";
    endcase
  endfunction

  // Expected control word for one cycle of the given phase.
  function automatic cw_t word(input int ph, input logic rdy, input logic z);
    cw_t w;
    w = '0;
    w.imm_src = imm_of(cur_op);
    w.instret = exp_cnt();
    case (ph)
      PH_FETCH: begin
        w.mem_read = 1'b1; w.alu_src_b = 2'b10; w.result_src = 2'b10;
        w.ir_write = rdy;  w.pc_write = rdy;
      end
      PH_DECODE: begin w.alu_src_a = 2'b01; w.alu_src_b = 2'b01; end
      PH_MEMADR: begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b01; end
      PH_MEMRD:  begin w.adr_src = 1'b1; w.mem_read = 1'b1; end
      PH_MEMWB:  begin w.result_src = 2'b01; w.reg_write = 1'b1; end
      PH_MEMWR:  begin w.adr_src = 1'b1; w.mem_write = 1'b1; end
      PH_EXECR:  begin w.alu_src_a = 2'b10; w.alu_op = 2'b10; end
      PH_EXECI:  begin w.alu_src_a = 2'b10; w.alu_src_b = 2'b01; w.alu_op = 2'b11; end
      PH_JAL:    begin w.alu_src_a = 2'b01; w.alu_src_b = 2'b10; w.pc_write = 1'b1; end
      PH_ALUWB:  begin w.reg_write = 1'b1; end
      PH_BEQ:    begin w.alu_src_a = 2'b10; w.alu_op = 2'b01; w.pc_write = z; end
      default:   begin w.illegal_op = 1'b1; end
    endcase
    return w;
  endfunction

  // While reset is high: FETCH selects, every strobe low, counters cleared.
  function automatic cw_t rst_word();
    cw_t w;
    w = '0;
    w.alu_src_b  = 2'b10;
    w.result_src = 2'b10;
    w.imm_src    = imm_of(cur_op);
    return w;
  endfunction

  task automatic step(input int ph, input logic rdy, input logic z);
    @(posedge clk);
    #1;
    reset     = 1'b0;
    op        = cur_op;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back('{word(ph, rdy, z), ph_name(ph)});
  endtask

  task automatic rst_cycle();
    @(posedge clk);
    #1;
    reset     = 1'b1;
    op        = cur_op;
    mem_ready = rb();
    zero      = rb();
    retired   = '0;
    exp_q.push_back('{rst_word(), "reset"});
  endtask

  task automatic run_insn(input logic [6:0] o, input int fw, input int mw, input logic bz,
                          input int trap_n);
    cur_op = o;
    repeat (fw) step(PH_FETCH, 1'b0, rb());
    step(PH_FETCH, 1'b1, rb());
    step(PH_DECODE, rb(), rb());
    case (o)
      OP_LW: begin
        step(PH_MEMADR, rb(), rb());
        repeat (mw) step(PH_MEMRD, 1'b0, rb());
        step(PH_MEMRD, 1'b1, rb());
        step(PH_MEMWB, rb(), rb());
        retired++;
      end
      OP_SW: begin
        step(PH_MEMADR, rb(), rb());
        repeat (mw) step(PH_MEMWR, 1'b0, rb());
        step(PH_MEMWR, 1'b1, rb());
        retired++;
      end
      OP_R: begin
        step(PH_EXECR, rb(), rb());
        step(PH_ALUWB, rb(), rb());
        retired++;
      end
      OP_I: begin
        step(PH_EXECI, rb(), rb());
        step(PH_ALUWB, rb(), rb());
        retired++;
      end
      OP_JAL: begin
        step(PH_JAL, rb(), rb());
        step(PH_ALUWB, rb(), rb());
        retired++;
      end
      OP_BEQ: begin
        step(PH_BEQ, rb(), bz);
        retired++;
      end
      default: begin
        repeat (trap_n) step(PH_TRAP, rb(), rb());
      end
    endcase
  endtask

  // Store stalled in its write wait; reset lands mid-cycle and must kill the strobe at once.
  task automatic reset_mid_sw();
    cur_op = OP_SW;
    step(PH_FETCH, 1'b1, rb());
    step(PH_DECODE, rb(), rb());
    step(PH_MEMADR, rb(), rb());
    step(PH_MEMWR, 1'b0, rb());
    step(PH_MEMWR, 1'b0, rb());
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
    #2;
    reset   = 1'b1;
    retired = '0;
    exp_q.push_back('{rst_word(), "reset_mid_memwrite"});
    rst_cycle();
  endtask

  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      cw_t  a;
      e = exp_q.pop_front();
      a = {pc_write, adr_src, mem_read, mem_write, ir_write, reg_write, result_src, alu_src_a,
           alu_src_b, alu_op, imm_src, illegal_op, instret};
      n_checks++;
      if (a === e.w) begin
        n_pass++;
      end else begin
        $display("FAIL %s at %0t: got %h expected %h", e.tag, $time, a, e.w);
      end
    end
  end

  logic [6:0] ops [6] = '{OP_LW, OP_SW, OP_R, OP_I, OP_JAL, OP_BEQ};

  initial begin
    repeat (3) rst_cycle();

    for (int i = 0; i < 40; i++) begin
      run_insn(ops[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 3), rb(), 0);
    end

    run_insn(OP_LW, 0, 0, 1'b0, 0);
    run_insn(OP_SW, 0, 3, 1'b0, 0);
    run_insn(OP_BEQ, 0, 0, 1'b1, 0);
    run_insn(OP_BEQ, 0, 0, 1'b0, 0);
    repeat (16) run_insn(OP_I, $urandom_range(0, 1), 0, 1'b0, 0);

    reset_mid_sw();
    run_insn(OP_R, 1, 0, 1'b0, 0);

    run_insn(7'b1111111, 0, 0, 1'b0, 10);
    rst_cycle();
    run_insn(OP_JAL, 0, 0, 1'b0, 0);
    run_insn(OP_LW, 2, 2, 1'b0, 0);

    repeat (2) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) begin
      n_pass++;
    end else begin
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
